mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
// - Memory-side responder for the mem_in_type/mem_out_type protocol; answers the instruction-fetch
//   requests that the ITIM issues on imem_in on a miss or uncached load.
// - Backs requests with a word-wide synchronous block RAM and adds a programmable fixed latency.
// - Also services CPU-side writes (mem_wstrb) and fences.
// - One outstanding request at a time.
// PARAMETERS
// - mem_depth  4096   number of 32-bit words; power of two
// - base_addr  32'h0  byte address of word 0; window is [base_addr, base_addr+4*mem_depth)
// - latency    1      cycles from acceptance to mem_ready; legal range 1..15
// PORTS
// - clock    in   1    clock
// - reset    in   1    reset, synchronous, active-low
// - mem_in   in   mem_in_type   mem_valid, mem_fence, mem_spec, mem_instr, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]
// - mem_out  out  mem_out_type  mem_rdata[31:0], mem_ready
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=IDLE, counter=0, mem_ready=0, mem_rdata=0. RAM contents are not cleared.
// - Reset mid-request drops the pending request silently. No ready is produced and no write is performed
//   if the write has not yet committed.
// - States:
//   - IDLE -> BUSY when mem_valid==1. Capture addr/wdata/wstrb/fence and load counter=latency-1.
//   - BUSY: decrement counter each cycle. At counter==0, go to RESP.
//   - RESP: mem_ready=1 for exactly one cycle, then IDLE.
// - mem_ready and mem_rdata are registered outputs with no combinational path from mem_in. The initiator
//   drops mem_valid combinationally off mem_ready, so this avoids a combinational loop.
// - Latency: request sampled in cycle 0 gives mem_ready high in cycle `latency`. Back-to-back requests
//   therefore issue at most one every latency+1 cycles.
// - mem_valid is ignored in BUSY and RESP, since the initiator holds valid high until ready.
//   A valid seen in the RESP cycle belongs to the completed request. A new request is accepted from the cycle after RESP.
// - Decode, using word index = (mem_addr-base_addr)>>2, low 2 address bits ignored:
//   - fence (mem_fence==1): no RAM access; mem_rdata=0. Takes priority over everything else.
//   - out of window (addr<base_addr or addr>=base_addr+4*mem_depth): no access; mem_rdata=0 (no error signal).
//   - write (mem_wstrb!=0): byte-lane write of mem_wdata[8k+7:8k] where wstrb[k]=1, committed on the
//     acceptance edge; mem_rdata=0 at ready.
//   - read (mem_wstrb==0): RAM read issued on the acceptance edge. Data is held in a response register
//     until RESP; mem_rdata=RAM word.
// - mem_rdata==0 whenever mem_ready==0.
// - mem_spec and mem_instr are accepted but do not alter behaviour.
// - Read-after-write to the same word in consecutive requests returns the new data (the write has committed
//   before the next acceptance).
// - Arithmetic:
//   - window compare in 33-bit unsigned, so base_addr+4*mem_depth may equal 2^32 without wrap;
//   - counter is 4 bits, saturating at 0.
// TESTING
// - Read, latency=1:
//   - preload word 5 = 32'hDEADBEEF;
//   - valid with addr=base+0x14 in cycle 0 -> ready=1, rdata=DEADBEEF in cycle 1, ready=0 in cycle 2.
// - Latency=4, valid held high until ready:
//   - ready pulses once in cycle 4 only;
//   - held valid causes no second response;
//   - new valid in cycle 5 gets ready in cycle 9.
// - Byte write then read:
//   - word 2 = 0x11223344; write wdata=0xAABBCCDD, wstrb=4'b0101 -> ready with rdata=0;
//   - next read of word 2 -> 0x11BB33DD.
// - Out of window: read at base+4*mem_depth -> ready after `latency` cycles, rdata=0; RAM unchanged.
// - Fence: mem_fence=1 with wstrb=4'hF -> ready, rdata=0, no RAM write.
// - Reset mid-BUSY (latency=4):
//   - reset low in cycle 2 -> no ready in cycles 2..6;
//   - outputs 0 while reset is low;
//   - the next request completes normally.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder backed by a word-wide synchronous RAM with
//            a programmable fixed response latency; one request in flight.
// Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
    parameter int          MEM_DEPTH = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          LATENCY   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_fence,
    input  logic        mem_spec,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready
);

    localparam int          c_AW    = $clog2(MEM_DEPTH);
    localparam logic [32:0] c_BASE  = {1'b0, BASE_ADDR};
    // 33-bit so a window ending exactly at 2^32 does not wrap
    localparam logic [32:0] c_LIMIT = c_BASE + (33'(MEM_DEPTH) << 2);
    localparam logic [3:0]  c_LOAD  = 4'(LATENCY - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        is_read_q, is_read_d;

    logic [31:0] ram [MEM_DEPTH];
    logic [31:0] ram_rdata_q;

    logic [32:0]     w_addr33;
    logic            w_in_window;
    logic [31:0]     w_offset;
    logic [c_AW-1:0] w_index;
    logic            w_accept;
    logic            w_access;
    logic            w_write;
    logic            w_read;
    logic            w_unused;

    assign w_addr33    = {1'b0, mem_addr};
    assign w_in_window = (w_addr33 >= c_BASE) && (w_addr33 < c_LIMIT);
    assign w_offset    = mem_addr - BASE_ADDR;
    assign w_index     = w_offset[c_AW+1:2];

    // Fence outranks everything; write commits on the acceptance edge itself
    assign w_accept = reset && (state_q == c_IDLE) && mem_valid;
    assign w_access = w_accept && !mem_fence && w_in_window;
    assign w_write  = w_access && (mem_wstrb != 4'h0);
    assign w_read   = w_access && (mem_wstrb == 4'h0);

    assign w_unused = &{1'b0, mem_spec, mem_instr, w_offset[1:0], w_offset[31:c_AW+2]};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= c_IDLE;
            count_q   <= 4'd0;
            is_read_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            is_read_q <= is_read_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        is_read_d = is_read_q;
        case (state_q)
            c_IDLE: begin
                if (mem_valid) begin
                    is_read_d = w_read;
                    count_d   = c_LOAD;
                    state_d   = (c_LOAD == 4'd0) ? c_RESP : c_BUSY;
                end
            end
            c_BUSY: begin
                count_d = (count_q == 4'd0) ? 4'd0 : count_q - 4'd1;
                // RESP is the ready cycle, so leave BUSY as the count reaches zero
                if (count_q <= 4'd1) begin
                    state_d = c_RESP;
                end
            end
            c_RESP: begin
                state_d   = c_IDLE;
                is_read_d = 1'b0;
            end
            default: begin
                state_d   = c_IDLE;
                count_d   = 4'd0;
                is_read_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        mem_ready = (state_q == c_RESP);
        mem_rdata = (mem_ready && is_read_q) ? ram_rdata_q : 32'h0;
    end

    // RAM is never reset; the read register holds its word until RESP
    always_ff @(posedge clock) begin
        if (w_write) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_wstrb[k]) begin
                    ram[w_index][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
        if (w_read) begin
            ram_rdata_q <= ram[w_index];
        end
    end

endmodule
`default_nettype wire
